// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;
    typedef enum logic [2:0] {LEN0, LEN1, LOAD, WRITE, DRAIN, RUN, ERR} ldr_state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_W          = 16;
endpackage

// File: rtl/ldr_word_asm.sv
// Packs a byte stream into 32-bit little-endian words; byte 0 lands in bits [7:0].
module ldr_word_asm
    import imem_boot_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_en,
    input  logic        i_clear,
    output logic [31:0] o_word,
    output logic        o_word_full
);
    logic [1:0]  r_lane;
    logic [31:0] r_word;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_byte_en) begin
            r_word[{r_lane, 3'b000} +: 8] <= i_byte_in;
            r_lane                        <= r_lane + 2'd1;
        end
    end

    // Asserted in the same cycle as the last byte, so the word is complete one edge later.
    assign o_word_full = i_byte_en && !i_clear && (r_lane == 2'(BYTES_PER_WORD - 1));
    assign o_word      = r_word;
endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into imem, then releases the core.
//  state | meaning
//  LEN0  | wait for low length byte
//  LEN1  | wait for high length byte, range-check N
//  LOAD  | collect program bytes into the assembler
//  WRITE | one-cycle imem write of the assembled word
//  DRAIN | count RELEASE_DLY cycles before release
//  RUN   | core out of reset, reload on load_req
//  ERR   | bad length, core held in reset, reload on load_req
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          MAX_WORDS   = 1024,
    parameter int          RELEASE_DLY = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    input  logic        i_load_req,
    output logic [31:0] o_imem_din,
    output logic [31:0] o_imem_addr,
    output logic        o_imem_web,
    output logic        o_core_rstn,
    output logic        o_loading,
    output logic        o_done,
    output logic        o_err
);
    ldr_state_t         r_state, w_next;
    logic [7:0]         r_len_lo;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_idx;
    logic [15:0]        r_dly;
    logic [31:0]        r_din;
    logic [31:0]        r_addr;

    logic               w_accept;
    logic               w_clear;
    logic               w_byte_en;
    logic               w_word_full;
    logic [31:0]        w_word;
    logic [LEN_W-1:0]   w_len_in;
    logic [31:0]        w_addr_cur;
    logic               w_last;

    assign o_rx_ready  = (r_state == LEN0) || (r_state == LEN1) || (r_state == LOAD);
    assign w_accept    = i_rx_valid && o_rx_ready;
    assign w_byte_en   = w_accept && (r_state == LOAD);
    assign w_len_in    = {i_rx_data, r_len_lo};
    assign w_addr_cur  = BASE_ADDR + {14'd0, r_word_idx, 2'b00};
    assign w_last      = (r_word_idx + 16'd1) == r_len;

    ldr_word_asm u_asm (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_byte_in   (i_rx_data),
        .i_byte_en   (w_byte_en),
        .i_clear     (w_clear),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            LEN0:  if (w_accept) w_next = LEN1;
            LEN1: begin
                if (w_accept) begin
                    if ({16'd0, w_len_in} > 32'(MAX_WORDS)) w_next = ERR;
                    else if (w_len_in == '0)                w_next = DRAIN;
                    else                                    w_next = LOAD;
                end
            end
            LOAD:  if (w_word_full) w_next = WRITE;
            WRITE: w_next = w_last ? DRAIN : LOAD;
            DRAIN: if (r_dly == '0) w_next = RUN;
            RUN:   if (i_load_req) w_next = LEN0;
            ERR:   if (i_load_req) w_next = LEN0;
            default: w_next = LEN0;
        endcase
        w_clear = (w_next == LEN0) && (r_state != LEN0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= LEN0;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_dly      <= '0;
            r_din      <= '0;
            r_addr     <= BASE_ADDR;
        end else begin
            r_state <= w_next;
            if (w_accept && r_state == LEN0) r_len_lo <= i_rx_data;
            if (w_accept && r_state == LEN1) r_len    <= w_len_in;
            if (w_clear) begin
                r_word_idx <= '0;
                r_dly      <= '0;
            end else if (w_next == DRAIN && r_state != DRAIN) begin
                r_dly <= 16'(RELEASE_DLY - 1);
            end else if (r_state == DRAIN && r_dly != '0) begin
                r_dly <= r_dly - 16'd1;
            end
            if (r_state == WRITE) begin
                r_word_idx <= r_word_idx + 16'd1;
                r_din      <= w_word;
                r_addr     <= w_addr_cur;
            end
        end
    end

    // During WRITE the live word/address are shown; afterwards the held copies keep the bus stable.
    assign o_imem_din  = (r_state == WRITE) ? w_word     : r_din;
    assign o_imem_addr = (r_state == WRITE) ? w_addr_cur : r_addr;
    assign o_imem_web  = (r_state != WRITE);
    assign o_core_rstn = (r_state == RUN);
    assign o_loading   = (r_state != RUN) && (r_state != ERR);
    assign o_done      = (r_state == RUN);
    assign o_err       = (r_state == ERR);
endmodule
